// File: rtl/control_circuit_param.sv
// control_circuit_param: instruction-sequencing FSM for the register-file datapath.
// Decodes one latched instruction over 1-3 steps with a Run/Ready handshake and illegal flagging.
module control_circuit_param #(
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = 3,
    parameter int INSTR_W  = 11,
    parameter int DATA_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [INSTR_W-1:0]  INSTRUCTION,
    input  logic                Run,
    output logic                Ready,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic                ALU_a_in,
    output logic                ALU_g_in,
    output logic                ALU_g_out,
    output logic [1:0]          ALU_mode,
    output logic                External_data,
    output logic [DATA_W-1:0]   Imm,
    output logic                Done,
    output logic                Error
);
    localparam int IMM_W = INSTR_W - 3 - SEL_W;
    localparam logic [SEL_W-1:0] NR = SEL_W'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;
    state_t state;
    logic [INSTR_W-1:0] instr;

    logic [2:0]          op;
    logic [SEL_W-1:0]    rx, ry;
    logic [NUM_REGS-1:0] rx_oh, ry_oh;
    logic                t1, t2, t3, is_alu, bad_x, bad_y, ill, t1_ok;

    always_comb begin
        op     = instr[INSTR_W-1 -: 3];
        rx     = instr[INSTR_W-4 -: SEL_W];
        ry     = instr[IMM_W-1 -: SEL_W];
        t1     = state == T1;
        t2     = state == T2;
        t3     = state == T3;
        is_alu = op >= 3'd2 && op <= 3'd5;
        bad_x  = rx == '0 || rx > NR;
        bad_y  = ry == '0 || ry > NR;
        ill    = op == 3'd7 || (op != 3'd6 && bad_x) || (op != 3'd0 && op != 3'd6 && bad_y);
        t1_ok  = t1 && !ill;
        rx_oh  = NUM_REGS'(1) << (rx - 1'b1);
        ry_oh  = NUM_REGS'(1) << (ry - 1'b1);
        External_data = t1_ok && op == 3'd0;
        Rin       = ((t1_ok && op <= 3'd1) || t3) ? rx_oh : '0;
        Rout      = (t1_ok && op == 3'd1) ? ry_oh : (t1_ok && is_alu) ? rx_oh : t2 ? ry_oh : '0;
        ALU_a_in  = t1_ok && is_alu;
        ALU_g_in  = t2;
        ALU_g_out = t3;
        // add/sub/and/or sit at opcodes 2..5, so the mode is the opcode minus two
        ALU_mode  = t2 ? op[1:0] + 2'b10 : 2'b00;
        Done      = (t1 && !(t1_ok && is_alu)) || t3;
        Error     = t1 && ill;
        Ready     = state == IDLE || Done;
        Imm       = DATA_W'(instr[IMM_W-1:0]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            instr <= '0;
        end else if (Run && Ready) begin
            state <= T1;
            instr <= INSTRUCTION;
        end else if (Done || state == IDLE) begin
            state <= IDLE;
        end else begin
            state <= t1 ? T2 : T3;
        end
    end
endmodule

// File: tb/tb_control_circuit_param.sv
// tb_control_circuit_param: directed bench with a step-queue model of the control FSM.
// Each accepted instruction expands into its list of expected output steps.
module tb_control_circuit_param;
    logic        clk = 0, reset = 0, Run = 0;
    logic [10:0] INSTRUCTION = '0;
    logic        Ready, ALU_a_in, ALU_g_in, ALU_g_out, External_data, Done, Error;
    logic [3:0]  Rin, Rout;
    logic [1:0]  ALU_mode;
    logic [7:0]  Imm;
    int checks = 0, failures = 0, not_ready = 0;

    control_circuit_param #(.NUM_REGS(4), .SEL_W(3), .INSTR_W(11), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .INSTRUCTION(INSTRUCTION), .Run(Run), .Ready(Ready),
        .Rin(Rin), .Rout(Rout), .ALU_a_in(ALU_a_in), .ALU_g_in(ALU_g_in),
        .ALU_g_out(ALU_g_out), .ALU_mode(ALU_mode), .External_data(External_data),
        .Imm(Imm), .Done(Done), .Error(Error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] rin, rout;
        logic       a, gi, go;
        logic [1:0] mode;
        logic       ext, done, err;
    } step_t;

    step_t       q[$];
    logic [10:0] lat = '0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic [3:0] oh(input int r);
        return 4'(1 << (r - 1));
    endfunction

    task automatic expand(input logic [10:0] i);
        int op, x, y;
        step_t s;
        bit bad;
        op = int'(i[10:8]); x = int'(i[7:5]); y = int'(i[4:2]);
        bad = op == 7 || (op != 6 && (x < 1 || x > 4)) || (op != 0 && op != 6 && (y < 1 || y > 4));
        s = '0;
        if (bad) begin
            s.done = 1; s.err = 1; q.push_back(s);
        end else if (op == 0) begin
            s.rin = oh(x); s.ext = 1; s.done = 1; q.push_back(s);
        end else if (op == 1) begin
            s.rin = oh(x); s.rout = oh(y); s.done = 1; q.push_back(s);
        end else if (op == 6) begin
            s.done = 1; q.push_back(s);
        end else begin
            s.rout = oh(x); s.a = 1; q.push_back(s);
            s = '0; s.rout = oh(y); s.gi = 1; s.mode = 2'(op - 2); q.push_back(s);
            s = '0; s.go = 1; s.rin = oh(x); s.done = 1; q.push_back(s);
        end
    endtask

    // model advance on each rising edge
    initial forever begin
        bit rdy;
        @(posedge clk);
        if (!reset) begin
            q.delete();
            lat = '0;
        end else begin
            rdy = q.size() == 0 || q[0].done;
            if (q.size() != 0) void'(q.pop_front());
            if (Run && rdy) begin
                lat = INSTRUCTION;
                expand(INSTRUCTION);
            end
        end
    end

    // per-cycle comparison against the model
    initial forever begin
        step_t e;
        @(negedge clk);
        e = q.size() != 0 ? q[0] : step_t'('0);
        chk("ready", Ready, q.size() == 0 || e.done);
        chk("rin", Rin, e.rin);
        chk("rout", Rout, e.rout);
        chk("a_in", ALU_a_in, e.a);
        chk("g_in", ALU_g_in, e.gi);
        chk("g_out", ALU_g_out, e.go);
        chk("mode", ALU_mode, e.mode);
        chk("ext", External_data, e.ext);
        chk("done", Done, e.done);
        chk("error", Error, e.err);
        chk("imm", Imm, {3'b0, lat[4:0]});
        not_ready = Ready ? 0 : not_ready + 1;
        if (not_ready > 2) chk("ready_gap", not_ready, 2);
    end

    task automatic issue(input logic [10:0] i);
        @(negedge clk);
        Run = 1; INSTRUCTION = i;
        @(negedge clk);
        Run = 0;
    endtask

    initial begin
        int k;
        repeat (2) @(negedge clk);
        reset = 1;
        chk("rst_ready", Ready, 1);
        chk("rst_rin", Rin, 0);
        chk("rst_done", Done, 0);

        issue(11'b000_001_00110);
        chk("load_ext", External_data, 1);
        chk("load_rin", Rin, 4'b0001);
        chk("load_imm", Imm, 6);
        chk("load_done", Done, 1);

        issue(11'b001_001_010_00);
        chk("mov_rout", Rout, 4'b0010);
        chk("mov_rin", Rin, 4'b0001);
        chk("mov_err", Error, 0);

        issue(11'b011_011_100_00);
        chk("sub_t1_rout", Rout, 4'b0100);
        chk("sub_t1_a", ALU_a_in, 1);
        @(negedge clk);
        chk("sub_t2_rout", Rout, 4'b1000);
        chk("sub_t2_mode", ALU_mode, 2'b01);
        @(negedge clk);
        chk("sub_t3_go", ALU_g_out, 1);
        chk("sub_t3_rin", Rin, 4'b0100);
        chk("sub_t3_done", Done, 1);

        @(negedge clk);
        Run = 1; INSTRUCTION = 11'b010_001_010_00;
        k = 0;
        do begin @(negedge clk); k++; end while (!(Done && ALU_g_out) && k < 8);
        chk("b2b_add_done", Done, 1);
        INSTRUCTION = 11'b101_010_011_00;
        @(negedge clk);
        Run = 0;
        chk("b2b_or_a", ALU_a_in, 1);
        chk("b2b_or_rout", Rout, 4'b0010);
        repeat (3) @(negedge clk);

        issue(11'b111_001_001_00);
        chk("ill7_err", Error, 1);
        chk("ill7_done", Done, 1);
        chk("ill7_rin", Rin, 0);
        issue(11'b010_000_001_00);
        chk("illrx_err", Error, 1);
        chk("illrx_rout", Rout, 0);
        issue(11'b000_101_00011);
        chk("illload_err", Error, 1);
        issue(11'b110_000_00000);
        chk("nop_done", Done, 1);
        chk("nop_err", Error, 0);
        issue(11'b001_100_000_00);
        chk("illry_err", Error, 1);

        issue(11'b011_010_001_00);
        @(negedge clk);
        chk("abort_t2_gin", ALU_g_in, 1);
        reset = 0;
        @(negedge clk);
        reset = 1;
        chk("abort_done", Done, 0);
        chk("abort_ready", Ready, 1);
        chk("abort_rin", Rin, 0);
        chk("abort_imm", Imm, 0);

        @(negedge clk);
        Run = 1;
        foreach (q[j]) ;
        for (int j = 0; j < 12; j++) begin
            INSTRUCTION = 11'(j * 149 + 37);
            @(negedge clk);
        end
        Run = 0;
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
